// File: rtl/ghost_path_sched_if.sv
// Bundle between the ghost mode/movement logic and the shared path scheduler.
// The master side supplies tick, requests, tile fields and the engine result.
interface ghost_path_sched_if;
  logic        tick;
  logic [3:0]  req;
  logic [19:0] cur_x;
  logic [19:0] cur_y;
  logic [19:0] tgt_x;
  logic [19:0] tgt_y;
  logic [4:0]  eng_cur_x;
  logic [4:0]  eng_cur_y;
  logic [4:0]  eng_tgt_x;
  logic [4:0]  eng_tgt_y;
  logic [1:0]  eng_dir;
  logic [7:0]  ghost_dir;
  logic [3:0]  dir_valid;
  logic        busy;
  logic        round_done;
  logic        overrun;

  modport master (
    output tick, req, cur_x, cur_y, tgt_x, tgt_y, eng_dir,
    input  eng_cur_x, eng_cur_y, eng_tgt_x, eng_tgt_y,
    input  ghost_dir, dir_valid, busy, round_done, overrun
  );

  modport slave (
    input  tick, req, cur_x, cur_y, tgt_x, tgt_y, eng_dir,
    output eng_cur_x, eng_cur_y, eng_tgt_x, eng_tgt_y,
    output ghost_dir, dir_valid, busy, round_done, overrun
  );
endinterface

// File: rtl/ghost_path_sched.sv
// Round-robin time-sharing of one combinational shortest-path engine among four ghosts.
// Each served ghost takes LOAD, SETTLE x WAIT, CAPTURE; all outputs are registered.
module ghost_path_sched #(
  parameter int unsigned SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ghost_path_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StCapture} state_e;

  localparam logic [2:0] WaitLast = 3'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic [4:0]  eng_cur_x_q, eng_cur_x_d;
  logic [4:0]  eng_cur_y_q, eng_cur_y_d;
  logic [4:0]  eng_tgt_x_q, eng_tgt_x_d;
  logic [4:0]  eng_tgt_y_q, eng_tgt_y_d;
  logic [7:0]  ghost_dir_q, ghost_dir_d;
  logic [3:0]  dir_valid_q, dir_valid_d;
  logic        busy_q, busy_d;
  logic        round_done_q, round_done_d;
  logic        overrun_q, overrun_d;

  logic [4:0]  fld_lsb;
  logic [3:0]  sel_onehot;
  logic [3:0]  remaining;

  // First set bit of mask, scanning upward from start with wrap-around.
  function automatic logic [1:0] first_set(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    first_set = start;
    found     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && mask[idx]) begin
        first_set = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign fld_lsb    = 5'(sel_q) * 5'd5;
  assign sel_onehot = 4'b0001 << sel_q;
  assign remaining  = pending_q & ~sel_onehot;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    sel_d        = sel_q;
    rr_ptr_d     = rr_ptr_q;
    wcnt_d       = wcnt_q;
    eng_cur_x_d  = eng_cur_x_q;
    eng_cur_y_d  = eng_cur_y_q;
    eng_tgt_x_d  = eng_tgt_x_q;
    eng_tgt_y_d  = eng_tgt_y_q;
    ghost_dir_d  = ghost_dir_q;
    dir_valid_d  = dir_valid_q;
    round_done_d = 1'b0;
    overrun_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.tick) begin
          pending_d   = bus.req;
          dir_valid_d = 4'b0000;
          if (bus.req == 4'b0000) begin
            round_done_d = 1'b1;
          end else begin
            sel_d   = first_set(bus.req, rr_ptr_q);
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        // Operands are taken live here, so targets may move between tick and service.
        eng_cur_x_d = bus.cur_x[fld_lsb +: 5];
        eng_cur_y_d = bus.cur_y[fld_lsb +: 5];
        eng_tgt_x_d = bus.tgt_x[fld_lsb +: 5];
        eng_tgt_y_d = bus.tgt_y[fld_lsb +: 5];
        wcnt_d      = 3'd0;
        state_d     = StWait;
      end
      StWait: begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == WaitLast) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        ghost_dir_d[{sel_q, 1'b0} +: 2] = bus.eng_dir;
        dir_valid_d[sel_q]              = 1'b1;
        pending_d                       = remaining;
        rr_ptr_d                        = sel_q + 2'd1;
        if (remaining != 4'b0000) begin
          sel_d   = first_set(remaining, sel_q + 2'd1);
          state_d = StLoad;
        end else begin
          round_done_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A tick during a round is dropped; only flag it.
    if (state_q != StIdle && bus.tick) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pending_q    <= 4'b0000;
      sel_q        <= 2'd0;
      rr_ptr_q     <= 2'd0;
      wcnt_q       <= 3'd0;
      eng_cur_x_q  <= 5'd0;
      eng_cur_y_q  <= 5'd0;
      eng_tgt_x_q  <= 5'd0;
      eng_tgt_y_q  <= 5'd0;
      ghost_dir_q  <= 8'd0;
      dir_valid_q  <= 4'b0000;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      sel_q        <= sel_d;
      rr_ptr_q     <= rr_ptr_d;
      wcnt_q       <= wcnt_d;
      eng_cur_x_q  <= eng_cur_x_d;
      eng_cur_y_q  <= eng_cur_y_d;
      eng_tgt_x_q  <= eng_tgt_x_d;
      eng_tgt_y_q  <= eng_tgt_y_d;
      ghost_dir_q  <= ghost_dir_d;
      dir_valid_q  <= dir_valid_d;
      busy_q       <= busy_d;
      round_done_q <= round_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.eng_cur_x  = eng_cur_x_q;
  assign bus.eng_cur_y  = eng_cur_y_q;
  assign bus.eng_tgt_x  = eng_tgt_x_q;
  assign bus.eng_tgt_y  = eng_tgt_y_q;
  assign bus.ghost_dir  = ghost_dir_q;
  assign bus.dir_valid  = dir_valid_q;
  assign bus.busy       = busy_q;
  assign bus.round_done = round_done_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_ghost_path_sched.sv
// Scoreboard bench for ghost_path_sched: expected captures are queued at each tick and
// popped as dir_valid bits rise; a small XOR function stands in for the path engine.
module tb_ghost_path_sched;

  localparam int Per = 3;  // 2 + SETTLE with SETTLE = 1

  typedef struct {
    int         ghost;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ghost_path_sched_if bus ();

  ghost_path_sched #(.SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [1:0] eng_fn(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
    logic [4:0] t;
    t = a ^ b ^ c ^ d;
    return t[1:0] ^ t[3:2];
  endfunction

  assign bus.eng_dir = eng_fn(bus.eng_cur_x, bus.eng_cur_y, bus.eng_tgt_x, bus.eng_tgt_y);

  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb[$];
  logic [7:0] m_gdir = 8'd0;
  int         rr_m = 0;
  int         rd_cnt = 0;
  int         rd_cyc = -1;
  logic       rd_busy = 1'b0;
  int         ovr_cnt = 0;
  int         ovr_cyc = -1;
  logic [3:0] prev_v = 4'b0000;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [1:0] exp_dir(input int g);
    return eng_fn(bus.cur_x[5*g +: 5], bus.cur_y[5*g +: 5],
                  bus.tgt_x[5*g +: 5], bus.tgt_y[5*g +: 5]);
  endfunction

  // Queue the expected service order for a tick at cycle t0; returns the ghost count.
  function automatic int push_round(input logic [3:0] r, input int t0);
    int n;
    int g;
    int last;
    n    = 0;
    last = rr_m;
    for (int i = 0; i < 4; i++) begin
      g = (rr_m + i) % 4;
      if (r[g]) begin
        n++;
        sb.push_back('{g, exp_dir(g), t0 + 1 + n * Per});
        last = g;
      end
    end
    if (n > 0) rr_m = (last + 1) % 4;
    return n;
  endfunction

  always @(negedge clk) begin
    logic [3:0] new_v;
    exp_t       e;
    if (!rst_n) begin
      prev_v = 4'b0000;
    end else begin
      new_v = bus.dir_valid & ~prev_v;
      for (int g = 0; g < 4; g++) begin
        if (new_v[g]) begin
          if (sb.size() == 0) begin
            check("spurious_capture", 32'(sb.size()), 32'd1);
          end else begin
            e = sb.pop_front();
            check("cap_ghost", 32'(g), 32'(e.ghost));
            check("cap_cycle", 32'(cyc), 32'(e.cyc));
            check("cap_dir", 32'(bus.ghost_dir[2*g +: 2]), 32'(e.dir));
            m_gdir[2*e.ghost +: 2] = e.dir;
          end
        end
      end
      check("gdir_hold", 32'(bus.ghost_dir), 32'(m_gdir));
      prev_v = bus.dir_valid;
      if (bus.round_done) begin
        rd_cnt++;
        rd_cyc  = cyc;
        rd_busy = bus.busy;
      end
      if (bus.overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
    end
  end

  task automatic randomize_tiles();
    bus.cur_x = 20'($urandom);
    bus.cur_y = 20'($urandom);
    bus.tgt_x = 20'($urandom);
    bus.tgt_y = 20'($urandom);
  endtask

  // One tick with request r; req_off forces req to 0 at that offset, tick2 re-ticks.
  task automatic run_round(input logic [3:0] r, input int req_off, input int tick2);
    int t0;
    int n;
    int exp_done;
    int rd0;
    int ov0;
    @(posedge clk);
    #1;
    bus.req  = r;
    bus.tick = 1'b1;
    t0       = cyc;
    n        = push_round(r, t0);
    exp_done = t0 + 1 + n * Per;
    rd0      = rd_cnt;
    ov0      = ovr_cnt;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'(n > 0));
    while (cyc < exp_done + 3) begin
      @(posedge clk);
      #1;
      if (cyc - t0 == req_off) bus.req = 4'b0000;
      bus.tick = (cyc - t0 == tick2);
      if (n == 0) check("busy_empty", 32'(bus.busy), 32'd0);
    end
    check("round_done_cnt", 32'(rd_cnt - rd0), 32'd1);
    check("round_done_cyc", 32'(rd_cyc), 32'(exp_done));
    check("busy_at_done", 32'(rd_busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("dir_valid", 32'(bus.dir_valid), 32'(r));
    check("overrun_cnt", 32'(ovr_cnt - ov0), 32'(tick2 >= 0));
    if (tick2 >= 0) check("overrun_cyc", 32'(ovr_cyc), 32'(t0 + tick2 + 1));
    sb.delete();
  endtask

  initial begin
    int t0;
    int n;
    bus.tick = 1'b0;
    bus.req  = 4'b0000;
    randomize_tiles();

    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.tick = 1'($urandom);
      bus.req  = 4'($urandom);
      randomize_tiles();
      check("rst_gdir", 32'(bus.ghost_dir), 32'd0);
      check("rst_eng", 32'({bus.eng_cur_x, bus.eng_cur_y, bus.eng_tgt_x, bus.eng_tgt_y}), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.dir_valid), 32'd0);
    end
    bus.tick = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_outs", 32'({bus.ghost_dir, bus.dir_valid, bus.busy, bus.round_done,
                              bus.overrun}), 32'd0);
      check("idle_eng", 32'({bus.eng_cur_x, bus.eng_cur_y, bus.eng_tgt_x, bus.eng_tgt_y}),
            32'd0);
    end

    // Full round: engine yields 00/01/10/11 for ghosts 0..3.
    bus.cur_x = 20'd0;
    bus.cur_y = 20'd0;
    bus.tgt_y = 20'd0;
    bus.tgt_x = {5'd3, 5'd2, 5'd1, 5'd0};
    run_round(4'b1111, -1, -1);
    check("full_gdir", 32'(bus.ghost_dir), 32'(8'b11100100));

    randomize_tiles();
    run_round(4'b1010, -1, -1);
    run_round(4'b0000, -1, -1);
    randomize_tiles();
    run_round(4'b1111, 2, 5);

    for (int k = 0; k < 4; k++) begin
      randomize_tiles();
      run_round(4'($urandom_range(1, 15)), -1, -1);
    end

    // Reset at cycle 7 of a full round, then a fresh round must start at ghost 0.
    randomize_tiles();
    @(posedge clk);
    #1;
    bus.req  = 4'b1111;
    bus.tick = 1'b1;
    t0       = cyc;
    n        = push_round(4'b1111, t0);
    while (cyc < t0 + 7) begin
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_gdir = 8'd0;
    rr_m   = 0;
    check("midrst_gdir", 32'(bus.ghost_dir), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_valid", 32'(bus.dir_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    randomize_tiles();
    run_round(4'b1111, -1, -1);
    run_round(4'b0110, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
